lcd_bus_driver: RTL

- Downstream consumer of the team's 9-bit LCD command stream: bit 8 = RS, bits 7:0 = ASCII character (RS=1) or control code (RS=0); constants live in lcd_inst_pkg.
- Runs the HD44780 power-on initialisation itself.
- Accepts one command at a time over a valid/ready handshake.
- Drives the 8-bit parallel LCD bus (RS, RW, E, DB) with setup, enable-pulse, hold and execution-time spacing, all counted in clock cycles.

---
 rtl/lcd_inst_pkg.sv | 31 +++
 rtl/lcd_wait_timer.sv | 28 ++
 rtl/lcd_bus_driver.sv | 119 +++++++++++
 3 files changed

// File: rtl/lcd_inst_pkg.sv
// Shared constants for the 9-bit LCD command stream ({RS, code}) and the
// bus driver that plays it onto an HD44780 8-bit parallel interface.
package lcd_inst_pkg;

  localparam logic [8:0] CMD_CLEAR           = 9'h001;
  localparam logic [8:0] CMD_ENTRY_INC       = 9'h006;
  localparam logic [8:0] CMD_DISPLAY_OFF     = 9'h008;
  localparam logic [8:0] CMD_DISPLAY_ON      = 9'h00C;
  localparam logic [8:0] FUNC_SET_8BIT       = 9'h030;
  localparam logic [8:0] FUNC_SET_8BIT_2LINE = 9'h038;

  localparam int LCD_INIT_LEN = 8;

  // HD44780 power-on sequence: three wake-up writes, then configuration.
  localparam logic [8:0] LCD_INIT_ROM [LCD_INIT_LEN] = '{
    FUNC_SET_8BIT, FUNC_SET_8BIT, FUNC_SET_8BIT, FUNC_SET_8BIT_2LINE,
    CMD_DISPLAY_OFF, CMD_CLEAR, CMD_ENTRY_INC, CMD_DISPLAY_ON
  };

  typedef enum logic [2:0] {POWERUP, SETUP, PULSE, HOLD, WAIT, IDLE} lcd_bus_state_e;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution time.
  function automatic logic needs_long_wait(input logic [8:0] cmd);
    return !cmd[8] && (cmd[7:2] == 6'd0) && (cmd[1:0] != 2'd0);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// Loadable down-counter shared by all bus phases; expired flags the last
// cycle of the current phase and the count parks at zero when unused.
module lcd_wait_timer #(
  parameter int CNT_W     = 8,
  parameter int RESET_VAL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= CNT_W'(RESET_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == CNT_W'(1));

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 8-bit bus driver: runs the power-on init from ROM, then accepts
// one {RS, code} command per valid/ready transfer and paces every bus write.
module lcd_bus_driver
  import lcd_inst_pkg::*;
#(
  parameter int T_POWERUP_CYC   = 750000,
  parameter int T_INIT_CYC      = 205000,
  parameter int T_SETUP_CYC     = 2,
  parameter int T_EN_CYC        = 13,
  parameter int T_HOLD_CYC      = 1,
  parameter int T_EXEC_CYC      = 2000,
  parameter int T_EXEC_LONG_CYC = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int T_MAX = max_int(max_int(max_int(T_POWERUP_CYC, T_INIT_CYC),
                                         max_int(T_SETUP_CYC, T_EN_CYC)),
                                 max_int(max_int(T_HOLD_CYC, T_EXEC_CYC), T_EXEC_LONG_CYC));
  localparam int CNT_W = $clog2(T_MAX) + 1;
  localparam logic [2:0] LAST_IDX = 3'(LCD_INIT_LEN - 1);

  lcd_bus_state_e   state, state_nxt;
  logic [2:0]       init_idx;
  logic [CNT_W-1:0] load_val, wait_cyc;
  logic             load, expired, accept;

  assign cmd_ready = (state == IDLE) && init_done;
  assign accept    = cmd_valid && cmd_ready;
  assign lcd_rw    = 1'b0;

  lcd_wait_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (T_POWERUP_CYC)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );

  // The first two wake-up writes need the long init gap regardless of code.
  always_comb begin
    wait_cyc = CNT_W'(T_EXEC_CYC);
    if (!init_done && init_idx < 3'd2) begin
      wait_cyc = CNT_W'(T_INIT_CYC);
    end else if (needs_long_wait({lcd_rs, lcd_data})) begin
      wait_cyc = CNT_W'(T_EXEC_LONG_CYC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= POWERUP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_val  = '0;
    unique case (state)
      POWERUP: if (expired) state_nxt = SETUP;
      SETUP:   if (expired) state_nxt = PULSE;
      PULSE:   if (expired) state_nxt = HOLD;
      HOLD:    if (expired) state_nxt = WAIT;
      WAIT:    if (expired) state_nxt = (!init_done && init_idx != LAST_IDX) ? SETUP : IDLE;
      IDLE:    if (accept)  state_nxt = SETUP;
      default: state_nxt = POWERUP;
    endcase
    // Every transition enters a different state, so a change means a fresh phase.
    load = (state_nxt != state);
    case (state_nxt)
      SETUP:   load_val = CNT_W'(T_SETUP_CYC);
      PULSE:   load_val = CNT_W'(T_EN_CYC);
      HOLD:    load_val = CNT_W'(T_HOLD_CYC);
      WAIT:    load_val = wait_cyc;
      default: load_val = '0;
    endcase
  end

  // RS/DB only change on entry to SETUP, so they are frozen through WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_en    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= '0;
      init_idx  <= '0;
      init_done <= 1'b0;
    end else begin
      lcd_en <= (state_nxt == PULSE);
      if (accept) begin
        {lcd_rs, lcd_data} <= cmd_data;
      end else if (state == POWERUP && expired) begin
        init_idx           <= '0;
        {lcd_rs, lcd_data} <= LCD_INIT_ROM[0];
      end else if (state == WAIT && expired && !init_done) begin
        if (init_idx == LAST_IDX) begin
          init_done <= 1'b1;
        end else begin
          init_idx           <= init_idx + 3'd1;
          {lcd_rs, lcd_data} <= LCD_INIT_ROM[init_idx + 3'd1];
        end
      end
    end
  end

endmodule
